// File: rtl/rab_cfg_regfile.sv
// rtl/rab_cfg_regfile.sv - AXI4-Lite register file holding RAB slice configuration words
//
// Purpose: owns N_REGS 64-bit configuration words (four per slice: min, max,
// offset, flags) and drives them flat to the slice lookup. A committed write to
// a valid index pulses invalidate for one cycle, so translations in flight are
// discarded.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, synchronous active-low reset
//   s_aw*, s_w*, s_b*        AXI4-Lite write address / data / response channels
//   s_ar*, s_r*              AXI4-Lite read address / data channels
//   int_cfg_regs             config words; index 4*i+k belongs to slice i
//   invalidate               one-cycle pulse after a committed config write
module rab_cfg_regfile #(
    parameter int N_SLICES       = 16,
    parameter int N_REGS         = 4 * N_SLICES,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [63:0]               s_wdata,
    input  logic [7:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [63:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [N_REGS-1:0][63:0]   int_cfg_regs,
    output logic                      invalidate
);

    localparam int IDX_FULL_W = AXI_ADDR_WIDTH - 3;
    localparam int IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [IDX_FULL_W-1:0] N_REGS_A = IDX_FULL_W'(N_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    w_state_e                 w_state_q, w_state_d;
    r_state_e                 r_state_q, r_state_d;
    logic [IDX_FULL_W-1:0]    aw_idx_q, aw_idx_d;
    logic [63:0]              wdata_q, wdata_d;
    logic [7:0]               wstrb_q, wstrb_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     inval_q, inval_d;
    logic [N_REGS-1:0][63:0]  regs_q, regs_d;
    logic                     rvalid_q, rvalid_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [63:0]              rdata_q, rdata_d;

    // The byte offset within a 64-bit word carries no meaning here.
    logic [5:0] unused_addr_bits;
    assign unused_addr_bits = {s_awaddr[2:0], s_araddr[2:0]};

    logic [IDX_FULL_W-1:0] aw_idx_in;
    logic [IDX_FULL_W-1:0] ar_idx_in;
    assign aw_idx_in = s_awaddr[AXI_ADDR_WIDTH-1:3];
    assign ar_idx_in = s_araddr[AXI_ADDR_WIDTH-1:3];

    assign s_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
    assign s_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
    assign s_arready = (r_state_q == R_IDLE);

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // Write channel: collects AW and W in either order, then commits once.
    logic                  commit;
    logic                  c_ok;
    logic [IDX_FULL_W-1:0] c_idx_full;
    logic [IDX_W-1:0]      c_idx;
    logic [63:0]           c_data;
    logic [7:0]            c_strb;

    always_comb begin
        w_state_d  = w_state_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        inval_d    = 1'b0;
        regs_d     = regs_q;
        commit     = 1'b0;
        c_ok       = 1'b0;
        c_idx_full = aw_idx_q;
        c_idx      = '0;
        c_data     = wdata_q;
        c_strb     = wstrb_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    c_idx_full = aw_idx_in;
                    c_data     = s_wdata;
                    c_strb     = s_wstrb;
                end else if (aw_hs) begin
                    aw_idx_d  = aw_idx_in;
                    w_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d   = s_wdata;
                    wstrb_d   = s_wstrb;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = s_wdata;
                    c_strb = s_wstrb;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    c_idx_full = aw_idx_in;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (commit) begin
            c_ok      = (c_idx_full < N_REGS_A);
            c_idx     = c_idx_full[IDX_W-1:0];
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = c_ok ? RESP_OKAY : RESP_SLVERR;
            // An all-zero strobe still counts as a config change for invalidate.
            inval_d   = c_ok;
            if (c_ok) begin
                for (int b = 0; b < 8; b++) begin
                    if (c_strb[b]) begin
                        regs_d[c_idx][8*b +: 8] = c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read channel: samples the pre-edge register value, so a same-edge
    // write to the same index is not visible to this read.
    logic             ar_ok;
    logic [IDX_W-1:0] ar_idx;

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ar_ok     = (ar_idx_in < N_REGS_A);
        ar_idx    = ar_idx_in[IDX_W-1:0];

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d  = 1'b1;
                    rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = ar_ok ? regs_q[ar_idx] : 64'h0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            inval_q   <= 1'b0;
            regs_q    <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            inval_q   <= inval_d;
            regs_q    <= regs_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rresp      = rresp_q;
    assign s_rdata      = rdata_q;
    assign int_cfg_regs = regs_q;
    assign invalidate   = inval_q;

endmodule

// File: tb/tb_rab_cfg_regfile.sv
// tb/tb_rab_cfg_regfile.sv - testbench for rab_cfg_regfile
module tb_rab_cfg_regfile;

    localparam int N_SLICES = 16;
    localparam int N_REGS   = 4 * N_SLICES;
    localparam int AW       = 32;
    localparam int TMO      = 50;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [AW-1:0]           s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [63:0]             s_wdata;
    logic [7:0]              s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [AW-1:0]           s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [63:0]             s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;
    logic [N_REGS-1:0][63:0] cfg;
    logic                    invalidate;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] model [N_REGS];

    always #5 clk = ~clk;

    rab_cfg_regfile #(
        .N_SLICES       (N_SLICES),
        .N_REGS         (N_REGS),
        .AXI_ADDR_WIDTH (AW)
    ) dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .int_cfg_regs (cfg),
        .invalidate   (invalidate)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int b = 0; b < 8; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
        return (old & ~mask) | (data & mask);
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < N_REGS; i++) chk(tag, cfg[i], model[i]);
    endtask

    // Called and returns at a falling edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
        int          cyc;
        bit          aw_done, w_done, aw_fire, w_fire;
        logic [31:0] idx;
        bit          ok;
        idx = addr >> 3;
        ok  = (idx < N_REGS);
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < TMO) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_awaddr  = addr;
            s_wvalid  = !w_done && (cyc >= w_dly);
            s_wdata   = data;
            s_wstrb   = strb;
            chk("wr_no_early_inv", 64'(invalidate), 64'd0);
            chk("wr_no_early_bvalid", 64'(s_bvalid), 64'd0);
            aw_fire = s_awvalid && s_awready;
            w_fire  = s_wvalid && s_wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            @(negedge clk);
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("wr_handshake_done", 64'({aw_done, w_done}), 64'd3);
        if (ok) model[idx] = merge(model[idx], data, strb);
        chk("wr_bvalid", 64'(s_bvalid), 64'd1);
        chk("wr_bresp", 64'(s_bresp), ok ? 64'd0 : 64'd2);
        chk("wr_inv_pulse", 64'(invalidate), ok ? 64'd1 : 64'd0);
        if (ok) chk("wr_reg", cfg[idx], model[idx]);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bhold_bvalid", 64'(s_bvalid), 64'd1);
            chk("bhold_bresp", 64'(s_bresp), ok ? 64'd0 : 64'd2);
            chk("bhold_awready", 64'(s_awready), 64'd0);
            chk("bhold_wready", 64'(s_wready), 64'd0);
            chk("bhold_inv", 64'(invalidate), 64'd0);
        end
        s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0;
        chk("wr_bvalid_clr", 64'(s_bvalid), 64'd0);
        chk("wr_inv_clr", 64'(invalidate), 64'd0);
        chk("wr_awready_back", 64'(s_awready), 64'd1);
        chk("wr_wready_back", 64'(s_wready), 64'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly);
        logic [31:0] idx;
        bit          ok;
        logic [63:0] exp;
        idx = addr >> 3;
        ok  = (idx < N_REGS);
        exp = ok ? model[idx] : 64'h0;
        chk("rd_arready", 64'(s_arready), 64'd1);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("rd_rvalid", 64'(s_rvalid), 64'd1);
        chk("rd_rdata", s_rdata, exp);
        chk("rd_rresp", 64'(s_rresp), ok ? 64'd0 : 64'd2);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rhold_rvalid", 64'(s_rvalid), 64'd1);
            chk("rhold_rdata", s_rdata, exp);
            chk("rhold_arready", 64'(s_arready), 64'd0);
        end
        s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_rready = 1'b0;
        chk("rd_rvalid_clr", 64'(s_rvalid), 64'd0);
    endtask

    initial begin
        logic [31:0] ridx;
        logic [63:0] rval;

        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        for (int i = 0; i < N_REGS; i++) model[i] = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_all("reset_regs");
        chk("reset_awready", 64'(s_awready), 64'd1);
        chk("reset_wready", 64'(s_wready), 64'd1);
        chk("reset_arready", 64'(s_arready), 64'd1);
        chk("reset_bvalid", 64'(s_bvalid), 64'd0);
        chk("reset_rvalid", 64'(s_rvalid), 64'd0);
        chk("reset_inv", 64'(invalidate), 64'd0);
        chk("reset_rdata", s_rdata, 64'd0);
        do_read(32'h38, 0);

        // Same-cycle AW and W, flags word of slice 0
        do_write(32'h18, 64'hF, 8'hFF, 0, 0, 0);
        chk("slice0_flags", cfg[3], 64'hF);

        // W three cycles ahead of AW, partial strobe over all-ones
        do_write(32'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
        do_write(32'h08, 64'h1234_5678, 8'h0F, 3, 0, 0);
        chk("partial_strb", cfg[1], 64'hFFFF_FFFF_1234_5678);

        // Out-of-range index
        do_write(32'h200, 64'hDEAD_BEEF, 8'hFF, 0, 1, 0);
        check_all("oob_no_change");
        do_read(32'h200, 1);

        // Slow B handshake
        do_write(32'h30, 64'h55AA_55AA_0000_1111, 8'hF0, 1, 0, 5);
        do_write(32'h30, 64'h0, 8'h00, 0, 2, 0);

        // Same-edge read and write to index 2
        do_write(32'h10, 64'hA, 8'hFF, 0, 0, 0);
        s_wdata = 64'hB; s_wstrb = 8'hFF; s_wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_wvalid = 1'b0;
        chk("haw_w_wready", 64'(s_wready), 64'd0);
        s_awaddr = 32'h10; s_awvalid = 1'b1;
        s_araddr = 32'h10; s_arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        model[2] = 64'hB;
        chk("race_rvalid", 64'(s_rvalid), 64'd1);
        chk("race_old_data", s_rdata, 64'hA);
        chk("race_bvalid", 64'(s_bvalid), 64'd1);
        chk("race_inv", 64'(invalidate), 64'd1);
        chk("race_new_reg", cfg[2], 64'hB);
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        do_read(32'h10, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            ridx = $urandom_range(0, N_REGS + 3);
            rval = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0)
                do_write({ridx[28:0], 3'($urandom)}, rval, 8'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read({ridx[28:0], 3'($urandom)}, $urandom_range(0, 2));
        end
        check_all("random_regs");

        // Reset while holding an address
        do_write(32'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0);
        s_awaddr = 32'h28; s_awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0;
        chk("haw_awready", 64'(s_awready), 64'd0);
        chk("haw_wready", 64'(s_wready), 64'd1);
        rst_n = 1'b0;
        s_wdata = 64'h77; s_wstrb = 8'hFF; s_wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_wvalid = 1'b0;
        for (int i = 0; i < N_REGS; i++) model[i] = 64'h0;
        chk("mid_rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("mid_rst_inv", 64'(invalidate), 64'd0);
        chk("mid_rst_awready", 64'(s_awready), 64'd1);
        chk("mid_rst_wready", 64'(s_wready), 64'd1);
        check_all("mid_rst_regs");
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_bvalid", 64'(s_bvalid), 64'd0);
        do_write(32'h28, 64'h99, 8'h01, 0, 0, 0);
        check_all("final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
